// File: rtl/mandel_pkg.sv
// Shared constants and types for the Mandelbrot coordinate mappers.
package mandel_pkg;

  // Q10.21 fixed-point layout of coordinates, zoom and window operands
  localparam int unsigned FRAC_BITS = 21;
  localparam int unsigned INT_BITS  = 10;

  // Pixel coordinate width and default screen geometry
  localparam int unsigned PIX_W      = 10;
  localparam int unsigned DEF_WIDTH  = 640;
  localparam int unsigned DEF_HEIGHT = 480;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } c2p_state_t;

endpackage

// File: rtl/coord_to_pixel_if.sv
// Request/result handshake bundle for coord_to_pixel.
// master = requester/consumer side, slave = the mapper itself.
interface coord_to_pixel_if
  import mandel_pkg::*;
#(
  parameter int unsigned DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] re;
  logic [DATA_W-1:0] im;
  logic [DATA_W-1:0] zoom_factor;
  logic [DATA_W-1:0] re_lower;
  logic [DATA_W-1:0] im_upper;
  logic              out_valid;
  logic              out_ready;
  logic [PIX_W-1:0]  x;
  logic [PIX_W-1:0]  y;
  logic              in_range;

  modport master (
    output in_valid, re, im, zoom_factor, re_lower, im_upper, out_ready,
    input  in_ready, out_valid, x, y, in_range
  );

  modport slave (
    input  in_valid, re, im, zoom_factor, re_lower, im_upper, out_ready,
    output in_ready, out_valid, x, y, in_range
  );
endinterface

// File: rtl/serial_divider.sv
// Serial restoring divider, one quotient bit per cycle, MSB first.
// The first bit is resolved on the start edge itself, so QUOT_BITS edges
// (start included) produce the quotient; done pulses for one cycle after.
// overflow flags dividend >= divisor << QUOT_BITS (quotient would not fit).
// QUOT_BITS must be at least 2.
module serial_divider #(
  parameter int unsigned DVD_W     = 33,
  parameter int unsigned DVS_W     = 32,
  parameter int unsigned QUOT_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DVD_W-1:0]     dividend,
  input  logic [DVS_W-1:0]     divisor,
  output logic [QUOT_BITS-1:0] quotient,
  output logic                 overflow,
  output logic                 done
);
  localparam int unsigned CALC_W = (DVD_W > DVS_W + QUOT_BITS) ? DVD_W : DVS_W + QUOT_BITS;
  localparam int unsigned IDX_W  = $clog2(QUOT_BITS);

  logic [CALC_W-1:0]    rem_q, rem_cur, rem_d, trial;
  logic [DVS_W-1:0]     div_q, div_cur;
  logic [IDX_W-1:0]     idx_q, idx_cur;
  logic [QUOT_BITS-1:0] quot_q, quot_cur, quot_d;
  logic                 busy_q, done_q, ovf_q, active, ge;

  // One restoring step on either the fresh operands (start) or the held ones
  always_comb begin
    active   = start | busy_q;
    rem_cur  = start ? CALC_W'(dividend) : rem_q;
    div_cur  = start ? divisor : div_q;
    idx_cur  = start ? IDX_W'(QUOT_BITS - 1) : idx_q;
    quot_cur = start ? '0 : quot_q;
    trial    = CALC_W'(div_cur) << idx_cur;
    ge       = rem_cur >= trial;
    rem_d    = ge ? rem_cur - trial : rem_cur;
    quot_d   = {quot_cur[QUOT_BITS-2:0], ge};
  end

  // Divider state; quotient and overflow hold after done until the next start
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      div_q  <= '0;
      idx_q  <= '0;
      quot_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (start) begin
        div_q <= divisor;
        ovf_q <= CALC_W'(dividend) >= (CALC_W'(divisor) << QUOT_BITS);
      end
      if (active) begin
        rem_q  <= rem_d;
        quot_q <= quot_d;
        idx_q  <= idx_cur - 1'b1;
        busy_q <= idx_cur != '0;
      end
      done_q <= active && (idx_cur == '0);
    end
  end

  assign quotient = quot_q;
  assign overflow = ovf_q;
  assign done     = done_q;

endmodule

// File: rtl/coord_to_pixel.sv
// Complex point -> screen pixel mapper:
//   x = floor((re - re_lower) / zoom), y = floor((im_upper - im) / zoom)
// Optional build macro COORD_TO_PIXEL_ROUND_EN: round to nearest (ties up)
// by adding zoom>>1 to both dividends; latency is unchanged.
module coord_to_pixel
  import mandel_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned QUOT_BITS = 10,
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned HEIGHT    = DEF_HEIGHT
) (
  input logic             aclk,
  input logic             areset,
  coord_to_pixel_if.slave bus
);
  c2p_state_t state_q, state_d;

  logic [DATA_W-1:0]    re_q, im_q, zoom_q, re_lower_q, im_upper_q;
  logic                 fast_q;
  logic [PIX_W-1:0]     x_q, y_q;
  logic                 in_range_q, out_valid_q;

  logic signed [DATA_W:0] dx, dy;
  logic [DATA_W-1:0]      half;
  logic [DATA_W:0]        dvd_x, dvd_y;
  logic                   fast, div_start;
  logic [QUOT_BITS-1:0]   quot_x, quot_y;
  logic                   ovf_x, ovf_y, done_x, done_y;
  logic                   in_range_d;

  // Offsets from the window corner and the early-out decision
  always_comb begin
    dx = $signed({re_q[DATA_W-1], re_q}) - $signed({re_lower_q[DATA_W-1], re_lower_q});
    dy = $signed({im_upper_q[DATA_W-1], im_upper_q}) - $signed({im_q[DATA_W-1], im_q});
`ifdef COORD_TO_PIXEL_ROUND_EN
    half = zoom_q >> 1;
`else
    half = '0;
`endif
    // dx, dy are non-negative whenever they reach the dividers, so the sign bit is dropped
    dvd_x     = {1'b0, dx[DATA_W-1:0]} + {1'b0, half};
    dvd_y     = {1'b0, dy[DATA_W-1:0]} + {1'b0, half};
    fast      = dx[DATA_W] | dy[DATA_W] | zoom_q[DATA_W-1] | (zoom_q == '0);
    div_start = (state_q == PREP) && !fast;
  end

  serial_divider #(
    .DVD_W    (DATA_W + 1),
    .DVS_W    (DATA_W),
    .QUOT_BITS(QUOT_BITS)
  ) u_div_x (
    .clk     (aclk),
    .rst     (areset),
    .start   (div_start),
    .dividend(dvd_x),
    .divisor (zoom_q),
    .quotient(quot_x),
    .overflow(ovf_x),
    .done    (done_x)
  );

  serial_divider #(
    .DVD_W    (DATA_W + 1),
    .DVS_W    (DATA_W),
    .QUOT_BITS(QUOT_BITS)
  ) u_div_y (
    .clk     (aclk),
    .rst     (areset),
    .start   (div_start),
    .dividend(dvd_y),
    .divisor (zoom_q),
    .quotient(quot_y),
    .overflow(ovf_y),
    .done    (done_y)
  );

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.in_valid) state_d = PREP;
      PREP: state_d = fast ? DONE : DIV;
      DIV:  if (done_x && done_y) state_d = DONE;
      DONE: if (out_valid_q && bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Range check on the finished quotients
  always_comb begin
    in_range_d = !fast_q && !ovf_x && !ovf_y &&
                 (32'(quot_x) < WIDTH) && (32'(quot_y) < HEIGHT);
  end

  // FSM state, operand capture at accept, and the result register
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= IDLE;
      re_q        <= '0;
      im_q        <= '0;
      zoom_q      <= '0;
      re_lower_q  <= '0;
      im_upper_q  <= '0;
      fast_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      in_range_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.in_valid) begin
        re_q       <= bus.re;
        im_q       <= bus.im;
        zoom_q     <= bus.zoom_factor;
        re_lower_q <= bus.re_lower;
        im_upper_q <= bus.im_upper;
      end
      if (state_q == PREP) fast_q <= fast;
      // First DONE cycle registers the result; it then holds until taken
      if (state_q == DONE && !out_valid_q) begin
        out_valid_q <= 1'b1;
        in_range_q  <= in_range_d;
        x_q         <= in_range_d ? PIX_W'(quot_x) : '0;
        y_q         <= in_range_d ? PIX_W'(quot_y) : '0;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.in_range  = in_range_q;

endmodule

// File: tb/tb_coord_to_pixel.sv
// Randomized + directed bench for coord_to_pixel against a plain-arithmetic model.
module tb_coord_to_pixel;
  import mandel_pkg::*;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       r;
  } exp_t;

  localparam logic [31:0] ZOOM = 32'h0000_2000;
  localparam logic [31:0] RLO  = 32'hFFC0_0000;
  localparam logic [31:0] IUP  = 32'h0020_0000;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  bit   last_fast;

  coord_to_pixel_if #(.DATA_W(32)) bus ();

  coord_to_pixel #(
    .DATA_W   (32),
    .QUOT_BITS(10),
    .WIDTH    (640),
    .HEIGHT   (480)
  ) dut (
    .aclk  (aclk),
    .areset(areset),
    .bus   (bus)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the mapping formulas
  function automatic void model(input logic [31:0] re, input logic [31:0] im,
                                input logic [31:0] zm, input logic [31:0] rl,
                                input logic [31:0] iu, output bit fast, output exp_t e);
    longint dx, dy, z, qx, qy;
    dx = longint'($signed(re)) - longint'($signed(rl));
    dy = longint'($signed(iu)) - longint'($signed(im));
    z  = longint'($signed(zm));
    e.x = '0;
    e.y = '0;
    e.r = 1'b0;
    fast = (dx < 0) || (dy < 0) || (z <= 0);
    if (!fast) begin
`ifdef COORD_TO_PIXEL_ROUND_EN
      dx = dx + z / 2;
      dy = dy + z / 2;
`endif
      qx = dx / z;
      qy = dy / z;
      if (qx < 640 && qy < 480) begin
        e.x = 10'(qx);
        e.y = 10'(qy);
        e.r = 1'b1;
      end
    end
  endfunction

  // Every cycle a result is presented it must match the oldest outstanding expectation
  always @(negedge aclk) begin
    if (!areset && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        check("result", {bus.in_range, bus.x, bus.y}, {exp_q[0].r, exp_q[0].x, exp_q[0].y});
        check("in_ready_while_valid", bus.in_ready, 0);
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic accept(input logic [31:0] r, input logic [31:0] i, input logic [31:0] z,
                        input logic [31:0] l, input logic [31:0] u, output int waited);
    exp_t e;
    bit   f;
    model(r, i, z, l, u, f, e);
    last_fast = f;
    exp_q.push_back(e);
    bus.re = r;
    bus.im = i;
    bus.zoom_factor = z;
    bus.re_lower = l;
    bus.im_upper = u;
    bus.in_valid = 1'b1;
    waited = 0;
    while (!bus.in_ready && waited < 50) begin
      @(posedge aclk);
      #1;
      waited++;
    end
    if (!bus.in_ready) begin
      $display("FAIL accept_timeout: in_ready never rose");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "accept timeout");
    end
    @(posedge aclk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int exp_lat);
    int n;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge aclk);
      #1;
      n++;
    end
    check(name, n, exp_lat);
  endtask

  task automatic take(input int hold);
    repeat (hold) begin
      @(posedge aclk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge aclk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int w, n, sel, zp, lo, up, ofs;
    logic [31:0] r, i, z;
    logic [9:0] px;
    bit seen;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.re = '0;
    bus.im = '0;
    bus.zoom_factor = '0;
    bus.re_lower = '0;
    bus.im_upper = '0;

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_x", bus.x, 0);
    check("rst_y", bus.y, 0);
    check("rst_in_range", bus.in_range, 0);
    areset = 1'b0;
    @(posedge aclk);
    #1;

    // Nominal point (100, 50)
    accept(-32'sd3375104, 32'd1687552, ZOOM, RLO, IUP, w);
    wait_valid("t1_latency", 12);
    check("t1_x", bus.x, 100);
    check("t1_y", bus.y, 50);
    check("t1_in_range", bus.in_range, 1);
    take(0);

    // Left of column 0: fast path
    accept(RLO - 32'd1, IUP, ZOOM, RLO, IUP, w);
    wait_valid("t2_latency", 2);
    check("t2_in_range", bus.in_range, 0);
    check("t2_xy", {bus.x, bus.y}, 0);
    take(1);

    // Right edge boundary: column 639 in, 640 out; dx==0 is column 0
    accept(32'd1040384, IUP, ZOOM, RLO, IUP, w);
    wait_valid("t3a_latency", 12);
    check("t3a_x", bus.x, 639);
    check("t3a_in_range", bus.in_range, 1);
    take(0);
    accept(32'd1048576, IUP, ZOOM, RLO, IUP, w);
    wait_valid("t3b_latency", 12);
    check("t3b_in_range", bus.in_range, 0);
    check("t3b_x", bus.x, 0);
    take(0);
    accept(RLO, IUP, ZOOM, RLO, IUP, w);
    wait_valid("t3c_latency", 12);
    check("t3c_in_range", bus.in_range, 1);
    take(0);

    // Backpressure for 5 cycles, then back-to-back accept
    accept(-32'sd3375104, 32'd1687552, ZOOM, RLO, IUP, w);
    wait_valid("t4_latency", 12);
    repeat (5) begin
      @(posedge aclk);
      #1;
      check("t4_held_in_ready", bus.in_ready, 0);
      check("t4_held_valid", bus.out_valid, 1);
      check("t4_held_x", bus.x, 100);
    end
    take(0);
    accept(32'd1040384, IUP, ZOOM, RLO, IUP, w);
    check("t4_b2b_wait", w, 0);
    wait_valid("t4b_latency", 12);
    take(0);

    // Reset during DIV: the request is abandoned
    accept(-32'sd3375104, 32'd1687552, ZOOM, RLO, IUP, w);
    repeat (4) begin
      @(posedge aclk);
      #1;
    end
    areset = 1'b1;
    @(posedge aclk);
    #1;
    exp_q.delete();
    check("t5_out_valid", bus.out_valid, 0);
    check("t5_in_ready", bus.in_ready, 1);
    areset = 1'b0;
    seen = 0;
    repeat (16) begin
      @(posedge aclk);
      #1;
      if (bus.out_valid) seen = 1;
    end
    check("t5_no_stale_result", seen, 0);

    // Rounding tie and just-below-tie
`ifdef COORD_TO_PIXEL_ROUND_EN
    px = 10'd101;
`else
    px = 10'd100;
`endif
    accept(RLO + 32'd823296, IUP, ZOOM, RLO, IUP, w);
    wait_valid("t6a_latency", 12);
    check("t6a_x", bus.x, px);
    take(0);
    accept(RLO + 32'd823295, IUP, ZOOM, RLO, IUP, w);
    wait_valid("t6b_latency", 12);
    check("t6b_x", bus.x, 100);
    take(0);

    // Randomized transactions
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 9);
      z = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFF_E000 :
          (sel < 6) ? ZOOM : 32'($urandom_range(1, 20000));
      zp = (z == 0 || z[31]) ? 8192 : int'(z);
      lo = int'($urandom_range(0, 8000000)) - 4000000;
      up = int'($urandom_range(0, 8000000)) - 4000000;
      ofs = int'($urandom_range(0, 700 * zp)) - int'($urandom_range(0, 3 * zp));
      r = 32'(lo + ofs);
      ofs = int'($urandom_range(0, 520 * zp)) - int'($urandom_range(0, 3 * zp));
      i = 32'(up - ofs);
      if (sel == 9) r = $urandom;
      accept(r, i, z, 32'(lo), 32'(up), w);
      n = last_fast ? 2 : 12;
      wait_valid("rand_latency", n);
      take($urandom_range(0, 2));
    end

    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
